// File: rtl/reg_window_ctrl.sv
// ---------------------------------------------------------------------------
// reg_window_ctrl
//   Register-window controller for a SPARC V8 style integer register file.
//   Holds the Current Window Pointer (CWP) and Window Invalid Mask (WIM).
//   It sequences SAVE / RESTORE / trap-entry window moves and raises
//   window overflow and underflow traps. It also maps 5-bit logical register
//   numbers onto physical register-file selects.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   save       execute SAVE this cycle
//   restore    execute RESTORE this cycle
//   wr_cwp     software write of CWP (cwp_in ignored if >= NWIN)
//   cwp_in     CWP write data
//   wr_wim     software write of WIM
//   wim_in     WIM write data
//   trap_ack   trap unit accepted the pending window trap
//   ra, rb     logical source register numbers
//   rd         logical destination register number
//   sel_a/b    physical read selects (combinational from registered cwp)
//   sel_d      physical write select
//   cwp        current window pointer
//   wim        current window invalid mask
//   trap_req   window trap pending
//   trap_type  01 = overflow, 10 = underflow, 00 = none
// ---------------------------------------------------------------------------
module reg_window_ctrl #(
  parameter int NWIN  = 3,
  parameter int SEL_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             save,
  input  logic             restore,
  input  logic             wr_cwp,
  input  logic [1:0]       cwp_in,
  input  logic             wr_wim,
  input  logic [NWIN-1:0]  wim_in,
  input  logic             trap_ack,
  input  logic [4:0]       ra,
  input  logic [4:0]       rb,
  input  logic [4:0]       rd,
  output logic [SEL_W-1:0] sel_a,
  output logic [SEL_W-1:0] sel_b,
  output logic [SEL_W-1:0] sel_d,
  output logic [1:0]       cwp,
  output logic [NWIN-1:0]  wim,
  output logic             trap_req,
  output logic [1:0]       trap_type
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    TRAP = 1'b1
  } state_t;

  localparam logic [1:0] LAST_WIN = 2'(NWIN - 1);
  localparam logic [1:0] TT_NONE  = 2'b00;
  localparam logic [1:0] TT_OVF   = 2'b01;
  localparam logic [1:0] TT_UNF   = 2'b10;

  state_t            state_r, state_nxt_s;
  logic [1:0]        cwp_r, cwp_nxt_s;
  logic [NWIN-1:0]   wim_r, wim_nxt_s;
  logic [1:0]        trap_type_r, trap_type_nxt_s;
  logic [1:0]        cwp_dec_s, cwp_inc_s;

  function automatic logic [1:0] win_dec(input logic [1:0] w);
    return (w == 2'd0) ? LAST_WIN : (w - 2'd1);
  endfunction

  function automatic logic [1:0] win_inc(input logic [1:0] w);
    return (w == LAST_WIN) ? 2'd0 : (w + 2'd1);
  endfunction

  // Logical-to-physical map. Window w occupies 16 registers starting at
  // 8 + 16*w: outs first, then locals. The ins of w are the outs of inc(w).
  function automatic logic [SEL_W-1:0] phys_sel(input logic [4:0] r,
                                                input logic [1:0] w);
    logic [SEL_W-1:0] base;
    logic [SEL_W-1:0] ofs;
    ofs = SEL_W'(r[2:0]);
    case (r[4:3])
      2'b00:   phys_sel = SEL_W'(r);
      2'b01: begin
        base     = SEL_W'(8) + SEL_W'({w, 4'b0000});
        phys_sel = base + ofs;
      end
      2'b10: begin
        base     = SEL_W'(16) + SEL_W'({w, 4'b0000});
        phys_sel = base + ofs;
      end
      2'b11: begin
        base     = SEL_W'(8) + SEL_W'({win_inc(w), 4'b0000});
        phys_sel = base + ofs;
      end
      default: phys_sel = SEL_W'(0);
    endcase
  endfunction

  assign cwp_dec_s = win_dec(cwp_r);
  assign cwp_inc_s = win_inc(cwp_r);

  // State register: FSM state, CWP, WIM and the registered trap type.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cwp_r       <= 2'd0;
      wim_r       <= '0;
      trap_type_r <= TT_NONE;
    end else begin
      state_r     <= state_nxt_s;
      cwp_r       <= cwp_nxt_s;
      wim_r       <= wim_nxt_s;
      trap_type_r <= trap_type_nxt_s;
    end
  end

  // Next-state logic: window moves, trap raise/retire, software writes.
  always_comb begin
    state_nxt_s     = state_r;
    cwp_nxt_s       = cwp_r;
    trap_type_nxt_s = trap_type_r;

    case (state_r)
      IDLE: begin
        if (save && restore) begin
          // Illegal combination: neither executes.
          cwp_nxt_s = cwp_r;
        end else if (save) begin
          if (wim_r[cwp_dec_s]) begin
            state_nxt_s     = TRAP;
            trap_type_nxt_s = TT_OVF;
          end else begin
            cwp_nxt_s = cwp_dec_s;
          end
        end else if (restore) begin
          if (wim_r[cwp_inc_s]) begin
            state_nxt_s     = TRAP;
            trap_type_nxt_s = TT_UNF;
          end else begin
            cwp_nxt_s = cwp_inc_s;
          end
        end else begin
          cwp_nxt_s = cwp_r;
        end
      end
      TRAP: begin
        // Trap entry moves to a fresh window without consulting WIM.
        if (trap_ack) begin
          cwp_nxt_s       = cwp_dec_s;
          state_nxt_s     = IDLE;
          trap_type_nxt_s = TT_NONE;
        end else begin
          cwp_nxt_s = cwp_r;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        trap_type_nxt_s = TT_NONE;
      end
    endcase

    // Software CWP write wins over any window move; the FSM still advances.
    if (wr_cwp && (cwp_in <= LAST_WIN)) begin
      cwp_nxt_s = cwp_in;
    end else begin
      cwp_nxt_s = cwp_nxt_s;
    end

    if (wr_wim) begin
      wim_nxt_s = wim_in;
    end else begin
      wim_nxt_s = wim_r;
    end
  end

  // Output decode: trap request follows the registered FSM state.
  always_comb begin
    trap_req = 1'b0;
    case (state_r)
      IDLE:    trap_req = 1'b0;
      TRAP:    trap_req = 1'b1;
      default: trap_req = 1'b0;
    endcase
  end

  // Register-file selects, zero latency from the registered CWP.
  always_comb begin
    sel_a = phys_sel(ra, cwp_r);
    sel_b = phys_sel(rb, cwp_r);
    sel_d = phys_sel(rd, cwp_r);
  end

  assign cwp       = cwp_r;
  assign wim       = wim_r;
  assign trap_type = trap_type_r;

endmodule

// File: tb/tb_reg_window_ctrl.sv
// Directed bench for reg_window_ctrl (NWIN = 3, SEL_W = 6).
module tb_reg_window_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       save, restore, wr_cwp, wr_wim, trap_ack;
  logic [1:0] cwp_in;
  logic [2:0] wim_in;
  logic [4:0] ra, rb, rd;
  logic [5:0] sel_a, sel_b, sel_d;
  logic [1:0] cwp;
  logic [2:0] wim;
  logic       trap_req;
  logic [1:0] trap_type;

  int compared   = 0;
  int mismatched = 0;

  reg_window_ctrl #(.NWIN(3), .SEL_W(6)) dut (
    .clk(clk), .reset(reset), .save(save), .restore(restore),
    .wr_cwp(wr_cwp), .cwp_in(cwp_in), .wr_wim(wr_wim), .wim_in(wim_in),
    .trap_ack(trap_ack), .ra(ra), .rb(rb), .rd(rd),
    .sel_a(sel_a), .sel_b(sel_b), .sel_d(sel_d),
    .cwp(cwp), .wim(wim), .trap_req(trap_req), .trap_type(trap_type)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; save = 1'b0; restore = 1'b0; wr_cwp = 1'b0; wr_wim = 1'b0;
    trap_ack = 1'b0; cwp_in = 2'd0; wim_in = 3'b000;
    ra = 5'd0; rb = 5'd0; rd = 5'd0;
    step(); step();
    reset = 1'b0;

    // Reset state and address map at cwp = 0
    chk("rst_cwp", 32'(cwp), 32'd0);
    chk("rst_wim", 32'(wim), 32'd0);
    chk("rst_trap_req", 32'(trap_req), 32'd0);
    chk("rst_trap_type", 32'(trap_type), 32'd0);
    ra = 5'd5; rb = 5'd17; rd = 5'd24; #1;
    chk("map_global", 32'(sel_a), 32'd5);
    chk("map_local0", 32'(sel_b), 32'd17);
    chk("map_in0", 32'(sel_d), 32'd24);
    ra = 5'd9; #1;
    chk("map_out0", 32'(sel_a), 32'd9);

    // Save wraps 0 -> 2, selects follow new cwp
    save = 1'b1; step(); save = 1'b0;
    chk("save_wrap_cwp", 32'(cwp), 32'd2);
    ra = 5'd8; rb = 5'd24; rd = 5'd23; #1;
    chk("map_out2", 32'(sel_a), 32'd40);
    chk("map_in2_alias", 32'(sel_b), 32'd8);
    chk("map_local2_top", 32'(sel_d), 32'd55);
    restore = 1'b1; step(); restore = 1'b0;
    chk("restore_wrap_cwp", 32'(cwp), 32'd0);

    // Overflow trap
    wr_cwp = 1'b1; cwp_in = 2'd2; wr_wim = 1'b1; wim_in = 3'b010;
    step(); wr_cwp = 1'b0; wr_wim = 1'b0;
    chk("wr_cwp2", 32'(cwp), 32'd2);
    chk("wr_wim010", 32'(wim), 32'd2);
    save = 1'b1; step();
    chk("ovf_trap_req", 32'(trap_req), 32'd1);
    chk("ovf_trap_type", 32'(trap_type), 32'd1);
    chk("ovf_cwp_hold", 32'(cwp), 32'd2);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("trap_save_ignored_cwp", 32'(cwp), 32'd2);
      chk("trap_req_held", 32'(trap_req), 32'd1);
      chk("trap_type_held", 32'(trap_type), 32'd1);
    end
    save = 1'b0; trap_ack = 1'b1; step(); trap_ack = 1'b0;
    chk("ack_cwp", 32'(cwp), 32'd1);
    chk("ack_trap_req", 32'(trap_req), 32'd0);
    chk("ack_trap_type", 32'(trap_type), 32'd0);

    // Underflow trap, then reset while pending
    wr_cwp = 1'b1; cwp_in = 2'd0; step(); wr_cwp = 1'b0;
    restore = 1'b1; step(); restore = 1'b0;
    chk("unf_trap_req", 32'(trap_req), 32'd1);
    chk("unf_trap_type", 32'(trap_type), 32'd2);
    chk("unf_cwp_hold", 32'(cwp), 32'd0);
    reset = 1'b1; step(); reset = 1'b0;
    chk("midtrap_rst_req", 32'(trap_req), 32'd0);
    chk("midtrap_rst_type", 32'(trap_type), 32'd0);
    chk("midtrap_rst_cwp", 32'(cwp), 32'd0);
    chk("midtrap_rst_wim", 32'(wim), 32'd0);

    // Out-of-range CWP write ignored; save+restore together is a no-op
    wr_cwp = 1'b1; cwp_in = 2'd1; step();
    cwp_in = 2'd3; step(); wr_cwp = 1'b0;
    chk("wr_cwp3_ignored", 32'(cwp), 32'd1);
    save = 1'b1; restore = 1'b1; step(); save = 1'b0; restore = 1'b0;
    chk("save_restore_cwp", 32'(cwp), 32'd1);
    chk("save_restore_notrap", 32'(trap_req), 32'd0);

    // WIM write on the same edge as a save: check uses old wim (000)
    wr_wim = 1'b1; wim_in = 3'b001; save = 1'b1; step();
    wr_wim = 1'b0; save = 1'b0;
    chk("old_wim_save_cwp", 32'(cwp), 32'd0);
    chk("old_wim_notrap", 32'(trap_req), 32'd0);
    chk("new_wim", 32'(wim), 32'd1);

    // Overflow from cwp 0 (dec = 2), retire with trap_ack + wr_cwp
    wr_wim = 1'b1; wim_in = 3'b100; step(); wr_wim = 1'b0;
    save = 1'b1; step(); save = 1'b0;
    chk("ovf2_trap_req", 32'(trap_req), 32'd1);
    trap_ack = 1'b1; wr_cwp = 1'b1; cwp_in = 2'd1; step();
    trap_ack = 1'b0; wr_cwp = 1'b0;
    chk("ack_wrcwp_cwp", 32'(cwp), 32'd1);
    chk("ack_wrcwp_req", 32'(trap_req), 32'd0);
    chk("ack_wrcwp_type", 32'(trap_type), 32'd0);
    trap_ack = 1'b1; step(); trap_ack = 1'b0;
    chk("idle_ack_ignored", 32'(cwp), 32'd1);

    // Restore 2 -> 0 wrap with no invalid window in the way
    wr_wim = 1'b1; wim_in = 3'b000; wr_cwp = 1'b1; cwp_in = 2'd2; step();
    wr_wim = 1'b0; wr_cwp = 1'b0;
    restore = 1'b1; step(); restore = 1'b0;
    chk("restore_2to0", 32'(cwp), 32'd0);
    chk("restore_2to0_notrap", 32'(trap_req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/reg_window_ctrl.md
Name: reg_window_ctrl

Overview:
- Register-window controller for the SPARC V8 integer register file.
- Owns the Current Window Pointer (CWP) and Window Invalid Mask (WIM).
- Sequences SAVE, RESTORE and trap-entry window moves, and raises window overflow/underflow traps.
- Translates 5-bit logical register numbers into 6-bit physical selects that drive the 64-input register-file read muxes and the write decoder.

Parameters:
- NWIN, 3: number of register windows. Physical registers used = 8 + 16*NWIN (56 at default), which must be ≤ 64.
- SEL_W, 6: physical select width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- save  in  1  execute SAVE this cycle.
- restore  in  1  execute RESTORE this cycle.
- wr_cwp  in  1  software write of CWP.
- cwp_in  in  2  CWP write data.
- wr_wim  in  1  software write of WIM.
- wim_in  in  NWIN  WIM write data.
- trap_ack  in  1  trap unit accepted the pending window trap.
- ra, rb  in  5  logical source register numbers.
- rd  in  5  logical destination register number.
- sel_a, sel_b  out  SEL_W  physical read selects.
- sel_d  out  SEL_W  physical write select.
- cwp  out  2  current window pointer.
- wim  out  NWIN  current window invalid mask.
- trap_req  out  1  window trap pending.
- trap_type  out  2  01 = overflow, 10 = underflow, 00 = none.

Behaviour:
- Reset values: cwp = 0, wim = 0, trap_req = 0, trap_type = 00, FSM = IDLE. Reset mid-trap returns the FSM to IDLE and clears trap_req.
- All window arithmetic is modulo NWIN: dec(w) = (w == 0) ? NWIN-1 : w-1; inc(w) = (w == NWIN-1) ? 0 : w+1.
- Address map (combinational from the registered cwp; zero latency):
  - r0–r7 → r (globals).
  - r8–r15 → 8 + 16*cwp + (r-8) (outs).
  - r16–r23 → 8 + 16*cwp + 8 + (r-16) (locals).
  - r24–r31 → 8 + 16*inc(cwp) + (r-24) (ins alias the outs of window inc(cwp)).
  - The same function drives sel_a, sel_b and sel_d.
- A new cwp is visible on the selects in the cycle after the edge that updates it.
- FSM states: IDLE, TRAP.
- In IDLE, actions per edge in this priority order:
  - save && restore both high: illegal; neither executes, no state change.
  - save: if wim[dec(cwp)] == 1 → enter TRAP with trap_type = 01, cwp unchanged; else cwp <= dec(cwp).
  - restore: if wim[inc(cwp)] == 1 → enter TRAP with trap_type = 10, cwp unchanged; else cwp <= inc(cwp).
- In TRAP:
  - trap_req is held at 1 and trap_type is held stable; save and restore are ignored.
  - On trap_ack: cwp <= dec(cwp) (trap entry, no WIM check), trap_req <= 0, trap_type <= 00, FSM → IDLE.
  - trap_ack while in IDLE is ignored.
- wr_wim: wim <= wim_in on the edge, in any state. The WIM check in the same cycle uses the old wim.
- wr_cwp: cwp <= cwp_in if cwp_in < NWIN; otherwise the write is ignored and cwp is unchanged. Allowed in any state.
- Same-edge conflicts:
  - wr_cwp overrides the cwp update from save/restore/trap_ack. The trap FSM still transitions (a trap is still raised or retired).
  - trap_ack has priority over save/restore (they are ignored in TRAP anyway).
- trap_req and trap_type are registered: they assert in the cycle after the faulting save/restore.

Test Plan:
- Reset, cwp = 0 → ra = 5 gives sel_a = 5; ra = 9 gives 9; rb = 17 gives 17; rd = 24 gives 24; cwp = 0, wim = 000, trap_req = 0.
- wim = 000, pulse save → cwp = 2; next cycle ra = 8 gives sel_a = 40, rb = 24 gives sel_b = 8 (ins alias window 0 outs); pulse restore → cwp = 0.
- wr_cwp = 2 and wr_wim = 010, then save → next cycle trap_req = 1, trap_type = 01, cwp = 2; further saves ignored for 3 cycles; trap_ack → cwp = 1, trap_req = 0.
- cwp = 0, wim = 010, restore → trap_req = 1, trap_type = 10, cwp = 0; assert reset while pending → trap_req = 0, cwp = 0, wim = 000.
- wr_cwp with cwp_in = 3 (≥ NWIN) → cwp unchanged; save && restore in the same cycle → cwp unchanged and no trap.
- In TRAP, trap_ack and wr_cwp = 1 on the same edge → cwp = 1, FSM → IDLE, trap_req = 0.
